// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through read. Rev 1.0
`default_nettype none

module sync_fifo_flags #(
   parameter int DSIZE    = 8,
   parameter int ASIZE    = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wreq,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rreq,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int             DEPTH    = 1 << ASIZE;
   localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_LEVEL);
   localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_LEVEL);
   localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic [ASIZE:0]   count_next;
   logic             we;
   logic             re;

   // Accept decisions use only registered flags, so full+read and empty+write never bypass.
   assign we = wreq & ~wfull;
   assign re = rreq & ~rempty;

   always_comb begin
      count_next = count;
      if (we && !re)
         count_next = count + ONE;
      else if (re && !we)
         count_next = count - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         wfull        <= 1'b0;
         rempty       <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (we)
            wptr <= wptr + ONE;
         if (re)
            rptr <= rptr + ONE;
         count        <= count_next;
         wfull        <= (count_next == FULL_CNT);
         rempty       <= (count_next == '0);
         almost_full  <= (count_next >= AF_CNT);
         almost_empty <= (count_next <= AE_CNT);
         // A new error on the same edge as clr_err keeps the flag set.
         if (wreq && wfull)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (rreq && rempty)
            underflow <= 1'b1;
         else if (clr_err)
            underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wptr[ASIZE-1:0]] <= wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
      end else begin : g_std
         logic [DSIZE-1:0] rdata_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               rdata_q <= '0;
            else if (re)
               rdata_q <= mem[rptr[ASIZE-1:0]];
         end
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: drives a standard-read and an FWFT instance with identical stimulus
// and checks both against a queue-based model every cycle. Rev 1.0
`default_nettype none

module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wreq = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       rreq = 1'b0;
   logic       clr_err = 1'b0;

   logic [7:0] rdata_s, rdata_f;
   logic       wfull_s, rempty_s, af_s, ae_s, ovf_s, unf_s;
   logic       wfull_f, rempty_f, af_f, ae_f, ovf_f, unf_f;
   logic [4:0] count_s, count_f;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .wreq(wreq), .wdata(wdata), .rreq(rreq), .rdata(rdata_s),
      .wfull(wfull_s), .rempty(rempty_s), .almost_full(af_s), .almost_empty(ae_s),
      .count(count_s), .overflow(ovf_s), .underflow(unf_s), .clr_err(clr_err));

   sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .wreq(wreq), .wdata(wdata), .rreq(rreq), .rdata(rdata_f),
      .wfull(wfull_f), .rempty(rempty_f), .almost_full(af_f), .almost_empty(ae_f),
      .count(count_f), .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err));

   // Reference model: a queue of stored words plus sticky flags and the last popped word.
   logic [7:0] q[$];
   logic       m_over = 1'b0;
   logic       m_under = 1'b0;
   logic [7:0] m_rdata = 8'h00;
   bit         m_full, m_empty;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_over  = 1'b0;
         m_under = 1'b0;
         m_rdata = 8'h00;
      end else begin
         m_full  = (q.size() == 16);
         m_empty = (q.size() == 0);
         if (clr_err) begin
            m_over  = 1'b0;
            m_under = 1'b0;
         end
         if (wreq && m_full)  m_over  = 1'b1;
         if (rreq && m_empty) m_under = 1'b1;
         if (rreq && !m_empty) m_rdata = q.pop_front();
         if (wreq && !m_full)  q.push_back(wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int n;
      n = q.size();
      check("count_s",  32'(count_s), 32'(n));
      check("count_f",  32'(count_f), 32'(n));
      check("wfull_s",  32'(wfull_s),  32'(n == 16));
      check("wfull_f",  32'(wfull_f),  32'(n == 16));
      check("rempty_s", 32'(rempty_s), 32'(n == 0));
      check("rempty_f", 32'(rempty_f), 32'(n == 0));
      check("afull_s",  32'(af_s),     32'(n >= 12));
      check("afull_f",  32'(af_f),     32'(n >= 12));
      check("aempty_s", 32'(ae_s),     32'(n <= 2));
      check("aempty_f", 32'(ae_f),     32'(n <= 2));
      check("ovf_s",    32'(ovf_s),    32'(m_over));
      check("ovf_f",    32'(ovf_f),    32'(m_over));
      check("unf_s",    32'(unf_s),    32'(m_under));
      check("unf_f",    32'(unf_f),    32'(m_under));
      check("rdata_s",  32'(rdata_s),  32'(m_rdata));
      check("rdata_f",  32'(rdata_f),  (n == 0) ? 32'h0 : 32'(q[0]));
   end

   // Called at a falling edge: applies inputs, returns at the next falling edge.
   task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
      wreq = w; wdata = d; rreq = r; clr_err = c;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] prev;
      int pw, pr;
      @(negedge clk);
      @(negedge clk);
      check("rst_count", 32'(count_s), 32'd0);
      check("rst_rempty", 32'(rempty_s), 32'd1);
      check("rst_aempty", 32'(ae_s), 32'd1);
      check("rst_rdata", 32'(rdata_s), 32'd0);
      rst_n = 1'b1;
      idle();

      // Fill 1..16, then overflow attempt, clear, drain in order.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         check("fill_count", 32'(count_s), 32'(i));
         check("fill_aempty", 32'(ae_s), 32'(i <= 2));
         check("fill_afull", 32'(af_s), 32'(i >= 12));
      end
      check("fill_wfull", 32'(wfull_s), 32'd1);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      check("ovf_count", 32'(count_s), 32'd16);
      check("ovf_flag", 32'(ovf_s), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", 32'(ovf_s), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         check("drain_data", 32'(rdata_s), 32'(i));
      end
      check("drain_rempty", 32'(rempty_s), 32'd1);
      check("drain_noerr", 32'({ovf_s, unf_s}), 32'd0);

      // Underflow with same-edge clear: set wins, rdata holds.
      prev = m_rdata;
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      check("unf_flag", 32'(unf_s), 32'd1);
      check("unf_count", 32'(count_s), 32'd0);
      check("unf_rdata", 32'(rdata_s), 32'(prev));
      drive(1'b0, 8'h00, 1'b0, 1'b1);

      // Simultaneous read/write at count 5.
      for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
         check("simul5_count", 32'(count_s), 32'd5);
         check("simul5_data", 32'(rdata_s), 32'(i + 1));
      end
      check("simul5_head_f", 32'(rdata_f), 32'h05);

      // Simultaneous at full: read wins, write flagged.
      for (int i = 0; i < 11; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      drive(1'b1, 8'hBB, 1'b1, 1'b0);
      check("simulF_count", 32'(count_s), 32'd15);
      check("simulF_ovf", 32'(ovf_s), 32'd1);
      for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);

      // Simultaneous at empty: write wins, read flagged.
      drive(1'b1, 8'h77, 1'b1, 1'b0);
      check("simulE_count", 32'(count_s), 32'd1);
      check("simulE_unf", 32'(unf_s), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);

      // FWFT visibility.
      drive(1'b1, 8'h5A, 1'b0, 1'b0);
      check("fwft_rempty", 32'(rempty_f), 32'd0);
      check("fwft_rdata", 32'(rdata_f), 32'h5A);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("fwft_pop_rempty", 32'(rempty_f), 32'd1);
      check("fwft_pop_rdata", 32'(rdata_f), 32'h00);

      // Asynchronous reset between edges with 7 words stored.
      for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      wreq = 1'b0; wdata = 8'h00; rreq = 1'b0; clr_err = 1'b0;
      check("pre_rst_count", 32'(count_s), 32'd6);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count_s), 32'd0);
      check("arst_rempty", 32'(rempty_s), 32'd1);
      check("arst_aempty", 32'(ae_s), 32'd1);
      check("arst_rdata", 32'(rdata_s), 32'd0);
      check("arst_rdata_f", 32'(rdata_f), 32'd0);
      check("arst_flags", 32'({ovf_s, unf_s, wfull_s, af_s}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'h33, 1'b0, 1'b0);
      check("post_rst_f", 32'(rdata_f), 32'h33);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("post_rst_s", 32'(rdata_s), 32'h33);
      check("post_rst_empty", 32'(rempty_s), 32'd1);

      // Randomized traffic with shifting read/write bias to visit full and empty.
      for (int blk = 0; blk < 20; blk++) begin
         pw = (blk % 4 == 0) ? 85 : (blk % 4 == 2) ? 15 : 50;
         pr = 100 - pw;
         for (int i = 0; i < 80; i++)
            drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                  $urandom_range(0, 29) == 0);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
